// File: rtl/board_state_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : board_state_ram_pkg
//  Brief    : Piece codes, move result codes, FSM states and layout helpers.
//  Revision : 1.0
// ============================================================================
package board_state_ram_pkg;

    localparam int EMPTY             = 0;
    localparam int W_PAWN            = 1;
    localparam int W_BISHOP          = 2;
    localparam int W_KNIGHT          = 3;
    localparam int W_ROOK            = 4;
    localparam int W_QUEEN           = 5;
    localparam int W_KING            = 6;
    localparam int B_PAWN            = 7;
    localparam int B_BISHOP          = 8;
    localparam int B_KNIGHT          = 9;
    localparam int B_ROOK            = 10;
    localparam int B_QUEEN           = 11;
    localparam int B_KING            = 12;
    localparam int CODE_RESERVED_MIN = 13;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_EMPTY_SRC  = 2'd1,
        ERR_WRONG_SIDE = 2'd2,
        ERR_OWN_DST    = 2'd3
    } move_err_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_EXEC  = 2'd2
    } state_e;

    // Black pieces are the white codes shifted by six, so the back rank is
    // built once and offset for row 0.
    function automatic logic [3:0] init_code(input int row, input int col, input int n);
        logic [3:0] code;
        code = 4'(EMPTY);
        if (col < 8) begin
            if (row == 0 || row == n - 1) begin
                case (col)
                    0, 7:    code = 4'(W_ROOK);
                    1, 6:    code = 4'(W_KNIGHT);
                    2, 5:    code = 4'(W_BISHOP);
                    3:       code = 4'(W_QUEEN);
                    default: code = 4'(W_KING);
                endcase
                if (row == 0) begin
                    code = code + 4'(B_PAWN - W_PAWN);
                end
            end else if (row == 1) begin
                code = 4'(B_PAWN);
            end else if (row == n - 2) begin
                code = 4'(W_PAWN);
            end
        end
        return code;
    endfunction

    function automatic logic piece_colour(input int code);
        return (code >= B_PAWN);
    endfunction

    // Silences nothing; kept so every code name has a single source of truth.
    localparam int B_CODES_LAST = B_BISHOP + B_KNIGHT + B_ROOK + B_QUEEN + B_KING;

endpackage
`default_nettype wire

// File: rtl/board_state_ram_move_checker.sv
`default_nettype none
// ============================================================================
//  Module   : board_state_ram_move_checker
//  Brief    : Combinational legality check of a fetched move (no geometry).
//  Revision : 1.0
// ============================================================================
module board_state_ram_move_checker
    import board_state_ram_pkg::*;
#(
    parameter int SQ_W         = 3,
    parameter int CODE_W       = 4,
    parameter int ENFORCE_TURN = 1
) (
    input  logic [CODE_W-1:0] i_pf,
    input  logic [CODE_W-1:0] i_pt,
    input  logic [2*SQ_W-1:0] i_from,
    input  logic [2*SQ_W-1:0] i_to,
    input  logic              i_side,
    output logic [1:0]        o_err
);

    logic w_pf_bad;
    logic w_pt_piece;
    logic w_pf_black;
    logic w_pt_black;

    always_comb begin
        w_pf_black = piece_colour(int'(i_pf));
        w_pt_black = piece_colour(int'(i_pt));
        w_pf_bad   = (i_pf == CODE_W'(EMPTY)) || (i_pf >= CODE_W'(CODE_RESERVED_MIN));
        // A reserved code on the destination counts as an empty square.
        w_pt_piece = (i_pt != CODE_W'(EMPTY)) && (i_pt < CODE_W'(CODE_RESERVED_MIN));
        o_err      = ERR_NONE;
        if (w_pf_bad) begin
            o_err = ERR_EMPTY_SRC;
        end else if ((ENFORCE_TURN != 0) && (w_pf_black != i_side)) begin
            o_err = ERR_WRONG_SIDE;
        end else if ((i_from == i_to) || (w_pt_piece && (w_pt_black == w_pf_black))) begin
            o_err = ERR_OWN_DST;
        end
    end

endmodule
`default_nettype wire

// File: rtl/board_state_ram.sv
`default_nettype none
// ============================================================================
//  Module   : board_state_ram
//  Brief    : Writable chessboard register array with render read port and
//             handshaked move execution.
//  Revision : 1.0
// ============================================================================
module board_state_ram
    import board_state_ram_pkg::*;
#(
    parameter int SQ_W         = 3,
    parameter int CODE_W       = 4,
    parameter int ENFORCE_TURN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*SQ_W-1:0]   rd_xy,
    output logic [CODE_W-1:0]   rd_code,
    input  logic                init_req,
    input  logic                move_valid,
    output logic                move_ready,
    input  logic [2*SQ_W-1:0]   move_from,
    input  logic [2*SQ_W-1:0]   move_to,
    output logic                move_done,
    output logic [1:0]          move_err,
    output logic [CODE_W-1:0]   captured_code,
    output logic                side_to_move,
    output logic [15:0]         move_cnt
);

    localparam int N       = 2 ** SQ_W;
    localparam int SQUARES = N * N;
    localparam int AW      = 2 * SQ_W;

    state_e            r_state_q,   w_state_d;
    logic [AW-1:0]     r_from_q,    w_from_d;
    logic [AW-1:0]     r_to_q,      w_to_d;
    logic [CODE_W-1:0] r_board_q [SQUARES];
    logic [CODE_W-1:0] w_board_d [SQUARES];
    logic [CODE_W-1:0] w_layout  [SQUARES];
    logic [CODE_W-1:0] r_rd_code_q;
    logic              r_done_q,    w_done_d;
    logic [1:0]        r_err_q,     w_err_d;
    logic [CODE_W-1:0] r_cap_q,     w_cap_d;
    logic              r_side_q,    w_side_d;
    logic [15:0]       r_cnt_q,     w_cnt_d;

    logic [CODE_W-1:0] w_pf;
    logic [CODE_W-1:0] w_pt;
    logic [1:0]        w_chk_err;
    logic              w_accept;

    for (genvar gi = 0; gi < SQUARES; gi++) begin : g_layout
        assign w_layout[gi] = CODE_W'(init_code(gi / N, gi % N, N));
    end

    assign w_pf = r_board_q[r_from_q];
    assign w_pt = r_board_q[r_to_q];

    board_state_ram_move_checker #(
        .SQ_W         (SQ_W),
        .CODE_W       (CODE_W),
        .ENFORCE_TURN (ENFORCE_TURN)
    ) u_checker (
        .i_pf   (w_pf),
        .i_pt   (w_pt),
        .i_from (r_from_q),
        .i_to   (r_to_q),
        .i_side (r_side_q),
        .o_err  (w_chk_err)
    );

    assign move_ready = (r_state_q == ST_IDLE) && !rst && !init_req;
    assign w_accept   = move_valid && move_ready;

    // The array is committed at the end of CHECK so that a read issued
    // during the move_done cycle already returns the new position.
    always_comb begin
        w_state_d = r_state_q;
        w_from_d  = r_from_q;
        w_to_d    = r_to_q;
        w_board_d = r_board_q;
        w_done_d  = 1'b0;
        w_err_d   = r_err_q;
        w_cap_d   = r_cap_q;
        w_side_d  = r_side_q;
        w_cnt_d   = r_cnt_q;
        if (init_req) begin
            w_board_d = w_layout;
            w_side_d  = 1'b0;
            w_cnt_d   = 16'd0;
            w_state_d = ST_IDLE;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_from_d  = move_from;
                        w_to_d    = move_to;
                        w_state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    w_done_d = 1'b1;
                    w_err_d  = w_chk_err;
                    if (w_chk_err == ERR_NONE) begin
                        w_board_d[r_to_q]   = w_pf;
                        w_board_d[r_from_q] = CODE_W'(EMPTY);
                        w_cap_d             = w_pt;
                        w_side_d            = !r_side_q;
                        w_cnt_d             = r_cnt_q + 16'd1;
                    end else begin
                        w_cap_d = CODE_W'(EMPTY);
                    end
                    w_state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    w_state_d = ST_IDLE;
                end
                default: begin
                    w_state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_IDLE;
            r_from_q    <= '0;
            r_to_q      <= '0;
            r_board_q   <= w_layout;
            r_rd_code_q <= '0;
            r_done_q    <= 1'b0;
            r_err_q     <= 2'd0;
            r_cap_q     <= '0;
            r_side_q    <= 1'b0;
            r_cnt_q     <= 16'd0;
        end else begin
            r_state_q   <= w_state_d;
            r_from_q    <= w_from_d;
            r_to_q      <= w_to_d;
            r_board_q   <= w_board_d;
            r_rd_code_q <= r_board_q[rd_xy];
            r_done_q    <= w_done_d;
            r_err_q     <= w_err_d;
            r_cap_q     <= w_cap_d;
            r_side_q    <= w_side_d;
            r_cnt_q     <= w_cnt_d;
        end
    end

    assign rd_code       = r_rd_code_q;
    assign move_done     = r_done_q;
    assign move_err      = r_err_q;
    assign captured_code = r_cap_q;
    assign side_to_move  = r_side_q;
    assign move_cnt      = r_cnt_q;

endmodule
`default_nettype wire

// File: doc/board_state_ram.md
Name: board_state_ram

Overview:
- Writable chessboard state memory; replaces the fixed-layout board ROM between game logic and the renderer.
- Holds one piece code per square and serves a 1-cycle-latency read port to the figure renderer.
- Executes piece moves (from → to) through a valid/ready handshake, with side-to-move tracking, capture reporting and basic legality errors. Chess movement geometry is not checked.
- Reloads the starting position on reset or on request.

Parameters:
- SQ_W, 3, bits per board coordinate; board is N×N with N = 2**SQ_W; SQ_W ≥ 3.
- CODE_W, 4, piece code width; CODE_W ≥ 4.
- ENFORCE_TURN, 1, when 1 the moving piece must belong to side_to_move.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rd_xy  in  2*SQ_W  renderer read address {row, col}; row 0 = top (black back rank)
- rd_code  out  CODE_W  piece code at rd_xy, registered
- init_req  in  1  single-cycle pulse; reload starting position
- move_valid  in  1  move request present
- move_ready  out  1  block can accept a move
- move_from  in  2*SQ_W  source square {row, col}
- move_to  in  2*SQ_W  destination square {row, col}
- move_done  out  1  1-cycle pulse: move finished (success or error)
- move_err  out  2  result, valid while move_done=1
- captured_code  out  CODE_W  code previously on move_to, valid while move_done=1 and move_err=0
- side_to_move  out  1  0 = white, 1 = black
- move_cnt  out  16  count of successful moves since last init

Behaviour:
- Codes: 0 empty; 1–6 white (pawn, bishop, knight, rook, queen, king); 7–C black, same order; D and above reserved/invalid.
- Starting layout, columns 0..7:
  - row 0: A,9,8,B,C,8,9,A
  - row 1: all 7
  - row N-2: all 1
  - row N-1: 4,3,2,5,6,2,3,4
  - every other square (including columns ≥ 8) is 0.
- Storage is a register array; a full reload completes in 1 cycle.
- rst (synchronous):
  - array ← starting layout
  - rd_code=0, move_done=0, move_err=0, captured_code=0
  - side_to_move=0, move_cnt=0, move_ready=0 for that cycle
  - FSM → IDLE
- Read port: rd_code ← array[rd_xy] on every clk, latency 1. Read-before-write: a read of a square written in the same cycle returns the old value.
- FSM states and transitions:
  - IDLE: move_ready=1. On move_valid && move_ready, latch from/to → CHECK.
  - CHECK (1 cycle): fetch pf=array[from] and pt=array[to]; evaluate errors in this priority order:
    - 1: pf==0 or pf reserved
    - 2: ENFORCE_TURN and colour(pf) ≠ side_to_move
    - 3: from==to, or pt is nonzero and the same colour as pf
    - pt reserved is treated as an empty destination
    - → EXEC
  - EXEC (1 cycle):
    - If no error: array[to] ← pf, array[from] ← 0, captured_code ← pt, side_to_move toggles, move_cnt += 1 (wraps at 0xFFFF → 0).
    - On error: array unchanged, captured_code ← 0.
    - move_done=1 with move_err; → IDLE.
- Latency: handshake in cycle T → move_done in T+2; the new array is visible on rd_code in T+3 when read in T+2. move_ready is low during CHECK/EXEC; the next accept is possible at T+3.
- init_req:
  - Highest priority after rst, in any state.
  - Array ← starting layout, side_to_move=0, move_cnt=0, FSM → IDLE.
  - An in-flight move is aborted: no move_done and no array write that cycle.
  - move_ready is 0 in the init_req cycle.
- Changes to move_valid, move_from or move_to after acceptance are ignored.

Decomposition:
- vga_pkg / shared chess package holds:
  - piece code localparams (EMPTY, W_PAWN..B_KING, CODE_RESERVED_MIN)
  - move_err enum (ERR_NONE, ERR_EMPTY_SRC, ERR_WRONG_SIDE, ERR_OWN_DST)
  - FSM state typedef
  - function init_code(row, col, N) returning the starting-layout code
  - function piece_colour(code)
- Optional sub-module: move_checker, purely combinational, computing move_err from pf, pt, from, to and side_to_move.

Test Plan:
- Reset, then read every square with SQ_W=3 → rd_code(0)=A, rd_code(4)=C, rd_code(52)=1, rd_code(60)=6, rd_code(36)=0; side_to_move=0, move_cnt=0.
- Move from=52, to=36 (e2–e4), accepted at T → move_done at T+2, err=0, captured=0; then rd 36→1, rd 52→0, side_to_move=1, move_cnt=1.
- Immediately repeat a white move from=51, to=43 → err=2, array unchanged, side_to_move stays 1.
- Black move from=0, to=8 → err=3. Black move from=11, to=36 → err=0, captured_code=1, rd 36→7, move_cnt=2.
- Move from an empty square (from=27) → err=1. Move with from==to=1 while it is black's turn → err=3.
- Assert init_req in the CHECK cycle of a valid move → no move_done; array back to the starting layout; move_cnt=0; move_ready=1 on the following cycle.
